regwrite_arb: RTL and testbench
===============================

# regwrite_arb

Write-port arbiter and pending-write buffer for the integer register file. It shares the register file's single write port between two requesters: the writeback stage and the decode-stage early link write of return addresses (PC+4). Writeback is never stalled; link writes that cannot issue are held in a small FIFO and drained in idle write cycles. The block reports read hazards against buffered writes back to decode, and optionally forwards their data.

## Interface
Parameters:
- N, 64, register data width
- DEPTH, 2, link FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback write request
- wb_addr  in  5  writeback destination register
- wb_data  in  N  writeback data
- lnk_valid  in  1  decode link-write request
- lnk_addr  in  5  link destination (rd)
- lnk_data  in  N  link data (PC+4)
- lnk_ready  out  1  link request accepted this cycle
- flush  in  1  discard all buffered link writes
- ra1, ra2  in  5  decode read addresses
- hz1, hz2  out  1  read address matches a buffered write (decode must stall)
- fwd1_valid, fwd2_valid  out  1  forwarded data valid
- fwd1_data, fwd2_data  out  N  forwarded data
- we3  out  1  register-file write enable
- wa3  out  5  register-file write address
- wd3  out  N  register-file write data
- count  out  $clog2(DEPTH)+1  buffered entries

## Operation
- Write-port priority, evaluated each cycle:
  1. wb_valid
  2. FIFO head
  3. lnk_valid (direct path, only when the FIFO is empty)
- The write port is a combinational mux. The register file commits on the next edge.
- lnk_ready = (count < DEPTH). This is registered-state based, with no same-cycle credit from a dequeue.
- Accepted link request, not issued directly → enqueued at the tail. The direct issue and the enqueue never both occur.
- FIFO order is strict; a younger link write never passes an older one.
- Address 0:
  - wb/lnk writes to x0 are dropped: never driven on we3, never enqueued, lnk_ready unaffected.
  - hz and fwd are never asserted for ra = 0.
- Kill rule: on wb_valid with wb_addr equal to a buffered entry's address, that entry is invalidated on the edge. The writeback belongs to a younger instruction, so the buffered value is stale.
  - Invalid entries still occupy slots.
  - An invalid head is popped without asserting we3, and the write port passes to the next priority.
- hz1 = ra1 ≠ 0 and some valid buffered entry matches ra1 (same for hz2). If multiple entries match, the youngest valid one is used.
- The same-cycle lnk_valid is not considered for hazards; decode handles its own instruction.
- flush: all entries are cleared on the edge. Any lnk_valid in the same cycle is dropped. wb_valid in the same cycle still writes.

## Timing
- Reset: FIFO empty, count = 0, pointers 0.
- Outputs with inputs low: we3 = 0, wa3 = 0, wd3 = 0, lnk_ready = 1, hz/fwd = 0.
- Latency from request to we3:
  - wb: 0 cycles.
  - Direct link: 0 cycles.
  - Buffered link: issues on the first cycle with wb_valid = 0 after all older entries.
- count updates on the edge: +1 on enqueue, −1 on pop (valid or killed), both → unchanged.
- Full FIFO with wb_valid every cycle: lnk_ready stays 0 and no entry drains. This is permitted; the pipeline guarantees wb idle cycles.
- Reset asserted mid-operation immediately empties the FIFO. Pending writes are lost.

## Configuration
- REGWRITE_ARB_FWD_EN defined:
  - On a hazard match, fwdX_valid = 1 and fwdX_data = youngest valid matching entry data.
  - hzX is forced to 0 in that case.
- REGWRITE_ARB_FWD_EN undefined:
  - fwdX_valid = 0, fwdX_data = 0.
  - hzX asserts on a match as specified.

## Structure
- Shared package regwrite_pkg:
  - typedef regaddr_t (logic[4:0]).
  - struct pend_entry_t {valid, addr} (data stored separately, width N).
  - constant REG_ZERO = 5'd0.
- One sub-module, pend_fifo: circular buffer with head/tail/count, per-entry kill vector input, and a parallel compare port for two read addresses returning youngest-match index.
- regwrite_arb contains the priority mux, the kill/flush decode and the hazard/forward logic.

## Test plan
- Reset, then lnk_valid addr 1 data 0x1004 with wb idle → same-cycle we3 = 1, wa3 = 1, wd3 = 0x1004; count stays 0.
- wb_valid addr 5 and lnk_valid addr 1 simultaneously → we3 writes x5. Next idle cycle → x1 = PC+4 written, count 1 → 0.
- Fill FIFO (DEPTH = 2) under continuous wb_valid → lnk_ready = 0 with count = 2. Drop wb_valid → entries drain in order over 2 cycles.
- Buffered link x3, then wb_valid addr 3 data 0xAA → entry killed. The later idle pop has we3 = 0, and x3 holds 0xAA.
- Buffered link x7 with ra1 = 7:
  - Macro off → hz1 = 1.
  - Macro on → hz1 = 0, fwd1_valid = 1, fwd1_data = entry data.
  - ra2 = 0 → nothing asserted.
- Two buffered entries, then flush with lnk_valid high → count = 0 next cycle, no link write issued. Also assert reset mid-drain → we3 = 0 immediately.

Source files
------------

// File: rtl/regwrite_pkg.sv
// Shared types for the register-file write-port arbiter.
// Entry metadata lives here; entry data is held separately, N bits wide.
package regwrite_pkg;

   typedef logic [4:0] regaddr_t;

   typedef struct packed {
      logic     valid;
      regaddr_t addr;
   } pend_entry_t;

   localparam regaddr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regwrite_arb_pend_fifo.sv
// Pending link-write buffer: circular FIFO with per-entry kill and
// youngest-match lookup for two read ports (REGWRITE_ARB_FWD_EN gates data).
module pend_fifo
   import regwrite_pkg::*;
#(
   parameter  int N     = 64,
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  regaddr_t         push_addr,
   input  logic [N-1:0]     push_data,
   input  logic             pop,
   input  logic             flush,
   input  logic [DEPTH-1:0] kill,
   input  regaddr_t         ra1,
   input  regaddr_t         ra2,
   output pend_entry_t      ents [DEPTH],
   output logic             head_valid,
   output regaddr_t         head_addr,
   output logic [N-1:0]     head_data,
   output logic [CW-1:0]    count,
   output logic             hit1,
   output logic             hit2,
   output logic [N-1:0]     rd1_data,
   output logic [N-1:0]     rd2_data
);

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [N-1:0]  dat [DEPTH];
   logic [AW-1:0] idx;

   // Pointers, occupancy and entry metadata; popped slots are cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (kill[i]) ents[i].valid <= 1'b0;
         if (pop) begin
            ents[head].valid <= 1'b0;
            head <= head + AW'(1);
         end
         if (push) begin
            ents[tail] <= '{valid: 1'b1, addr: push_addr};
            tail <= tail + AW'(1);
         end
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   // Entry data storage, written at the tail.
   always_ff @(posedge clk) begin
      if (push && !flush) dat[tail] <= push_data;
   end

   assign head_valid = ents[head].valid;
   assign head_addr  = ents[head].addr;
   assign head_data  = dat[head];

   // Oldest-to-youngest scan; the last match seen is the youngest.
   always_comb begin
      hit1     = 1'b0;
      hit2     = 1'b0;
      rd1_data = '0;
      rd2_data = '0;
      idx      = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (ents[idx].valid && ents[idx].addr == ra1) begin
            hit1 = 1'b1;
`ifdef REGWRITE_ARB_FWD_EN
            rd1_data = dat[idx];
`endif
         end
         if (ents[idx].valid && ents[idx].addr == ra2) begin
            hit2 = 1'b1;
`ifdef REGWRITE_ARB_FWD_EN
            rd2_data = dat[idx];
`endif
         end
      end
   end

endmodule

// File: rtl/regwrite_arb.sv
// Register-file write-port arbiter: writeback > buffered link > direct link.
// REGWRITE_ARB_FWD_EN turns buffered-write hazards into forwarded data.
module regwrite_arb
   import regwrite_pkg::*;
#(
   parameter int N     = 64,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wb_valid,
   input  regaddr_t               wb_addr,
   input  logic [N-1:0]           wb_data,
   input  logic                   lnk_valid,
   input  regaddr_t               lnk_addr,
   input  logic [N-1:0]           lnk_data,
   output logic                   lnk_ready,
   input  logic                   flush,
   input  regaddr_t               ra1,
   input  regaddr_t               ra2,
   output logic                   hz1,
   output logic                   hz2,
   output logic                   fwd1_valid,
   output logic                   fwd2_valid,
   output logic [N-1:0]           fwd1_data,
   output logic [N-1:0]           fwd2_data,
   output logic                   we3,
   output regaddr_t               wa3,
   output logic [N-1:0]           wd3,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;

   pend_entry_t      ents [DEPTH];
   logic             head_valid;
   regaddr_t         head_addr;
   logic [N-1:0]     head_data;
   logic             hit1, hit2;
   logic [N-1:0]     rd1_data, rd2_data;
   logic [DEPTH-1:0] kill;
   logic             wb_go, empty, lnk_ok;
   logic             pop, direct, push;
   logic             m1, m2;

   assign wb_go     = wb_valid && wb_addr != REG_ZERO;
   assign empty     = count == '0;
   assign lnk_ready = count < CW'(DEPTH);
   assign lnk_ok    = lnk_valid && lnk_addr != REG_ZERO
                    && lnk_ready && !flush;
   assign pop       = !wb_go && !empty && !flush;
   assign direct    = lnk_ok && empty && !wb_go;
   assign push      = lnk_ok && !direct;

   // A younger writeback makes any buffered write to the same rd stale.
   always_comb begin
      kill = '0;
      for (int i = 0; i < DEPTH; i++)
         kill[i] = wb_go && ents[i].valid && ents[i].addr == wb_addr;
   end

   // Write-port mux; a killed head pops silently with we3 low.
   always_comb begin
      we3 = 1'b0;
      wa3 = REG_ZERO;
      wd3 = '0;
      unique case (1'b1)
         wb_go: begin
            we3 = 1'b1;
            wa3 = wb_addr;
            wd3 = wb_data;
         end
         pop: begin
            if (head_valid) begin
               we3 = 1'b1;
               wa3 = head_addr;
               wd3 = head_data;
            end
         end
         direct: begin
            we3 = 1'b1;
            wa3 = lnk_addr;
            wd3 = lnk_data;
         end
         default: ;
      endcase
   end

   pend_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_addr  (lnk_addr),
      .push_data  (lnk_data),
      .pop        (pop),
      .flush      (flush),
      .kill       (kill),
      .ra1        (ra1),
      .ra2        (ra2),
      .ents       (ents),
      .head_valid (head_valid),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .count      (count),
      .hit1       (hit1),
      .hit2       (hit2),
      .rd1_data   (rd1_data),
      .rd2_data   (rd2_data)
   );

   assign m1 = hit1 && ra1 != REG_ZERO;
   assign m2 = hit2 && ra2 != REG_ZERO;

   // rdX_data is zero from the buffer when forwarding is compiled out.
   assign fwd1_data = rd1_data;
   assign fwd2_data = rd2_data;

`ifdef REGWRITE_ARB_FWD_EN
   assign fwd1_valid = m1;
   assign fwd2_valid = m2;
   assign hz1        = 1'b0;
   assign hz2        = 1'b0;
`else
   assign fwd1_valid = 1'b0;
   assign fwd2_valid = 1'b0;
   assign hz1        = m1;
   assign hz2        = m2;
`endif

endmodule

// File: tb/tb_regwrite_arb.sv
// Testbench for regwrite_arb: directed vector table, reset-mid-drain
// sequence and a randomized run against a queue-based reference model.
module tb_regwrite_arb;

   localparam int N     = 64;
   localparam int DEPTH = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         wb_valid;
   logic [4:0]   wb_addr;
   logic [N-1:0] wb_data;
   logic         lnk_valid;
   logic [4:0]   lnk_addr;
   logic [N-1:0] lnk_data;
   logic         lnk_ready;
   logic         flush;
   logic [4:0]   ra1, ra2;
   logic         hz1, hz2;
   logic         fwd1_valid, fwd2_valid;
   logic [N-1:0] fwd1_data, fwd2_data;
   logic         we3;
   logic [4:0]   wa3;
   logic [N-1:0] wd3;
   logic [$clog2(DEPTH):0] count;

   int errors = 0;
   int checks = 0;

   regwrite_arb #(.N(N), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .lnk_valid  (lnk_valid),
      .lnk_addr   (lnk_addr),
      .lnk_data   (lnk_data),
      .lnk_ready  (lnk_ready),
      .flush      (flush),
      .ra1        (ra1),
      .ra2        (ra2),
      .hz1        (hz1),
      .hz2        (hz2),
      .fwd1_valid (fwd1_valid),
      .fwd2_valid (fwd2_valid),
      .fwd1_data  (fwd1_data),
      .fwd2_data  (fwd2_data),
      .we3        (we3),
      .wa3        (wa3),
      .wd3        (wd3),
      .count      (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wv;
      logic [4:0] wa;
      logic [N-1:0] wd;
      logic       lv;
      logic [4:0] la;
      logic [N-1:0] ld;
      logic       fl;
      logic [4:0] r1;
      logic [4:0] r2;
      logic       e_we;
      logic [4:0] e_wa;
      logic [N-1:0] e_wd;
      logic       e_rdy;
      int         e_cnt;
      logic       e_m1;
      logic       e_m2;
   } vec_t;

   typedef struct {
      logic       v;
      logic [4:0] a;
      logic [N-1:0] d;
   } ment_t;

   vec_t  tbl[$];
   ment_t q[$];

   function automatic vec_t mk(
      logic wv, logic [4:0] wa, logic [N-1:0] wd,
      logic lv, logic [4:0] la, logic [N-1:0] ld,
      logic fl, logic [4:0] r1, logic [4:0] r2,
      logic we, logic [4:0] ewa, logic [N-1:0] ewd,
      logic rdy, int cnt, logic m1, logic m2);
      vec_t v;
      v.wv = wv; v.wa = wa; v.wd = wd;
      v.lv = lv; v.la = la; v.ld = ld;
      v.fl = fl; v.r1 = r1; v.r2 = r2;
      v.e_we = we; v.e_wa = ewa; v.e_wd = ewd;
      v.e_rdy = rdy; v.e_cnt = cnt;
      v.e_m1 = m1; v.e_m2 = m2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] act,
                      input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, exp, $time);
      end
   endtask

   // Hazard/forward expectations depend on the build option.
   task automatic chk_match(input string tag, input logic m,
                            input logic [N-1:0] md, input logic hz,
                            input logic fv, input logic [N-1:0] fd,
                            input logic chk_data);
`ifdef REGWRITE_ARB_FWD_EN
      chk({tag, "_hz"}, N'(hz), N'(1'b0));
      chk({tag, "_fwdv"}, N'(fv), N'(m));
      if (chk_data) chk({tag, "_fwdd"}, fd, m ? md : '0);
`else
      chk({tag, "_hz"}, N'(hz), N'(m));
      chk({tag, "_fwdv"}, N'(fv), N'(1'b0));
      if (chk_data) chk({tag, "_fwdd"}, fd, '0);
`endif
   endtask

   task automatic drive(input logic wv, input logic [4:0] wa,
                        input logic [N-1:0] wd, input logic lv,
                        input logic [4:0] la, input logic [N-1:0] ld,
                        input logic fl, input logic [4:0] r1,
                        input logic [4:0] r2);
      wb_valid = wv; wb_addr = wa; wb_data = wd;
      lnk_valid = lv; lnk_addr = la; lnk_data = ld;
      flush = fl; ra1 = r1; ra2 = r2;
   endtask

   task automatic apply(input vec_t v, input int n);
      string s;
      drive(v.wv, v.wa, v.wd, v.lv, v.la, v.ld, v.fl, v.r1, v.r2);
      @(negedge clk);
      s = $sformatf("v%0d", n);
      chk({s, "_we3"}, N'(we3), N'(v.e_we));
      chk({s, "_wa3"}, N'(wa3), N'(v.e_wa));
      chk({s, "_wd3"}, wd3, v.e_wd);
      chk({s, "_rdy"}, N'(lnk_ready), N'(v.e_rdy));
      chk({s, "_cnt"}, N'(count), N'(v.e_cnt));
      chk_match({s, "_p1"}, v.e_m1, '0, hz1, fwd1_valid, fwd1_data, 1'b0);
      chk_match({s, "_p2"}, v.e_m2, '0, hz2, fwd2_valid, fwd2_data, 1'b0);
      @(posedge clk);
      #1;
   endtask

   // Reference: queue of pending link writes, evaluated per cycle.
   task automatic rand_step(input int n);
      logic         wv, lv, fl, wbg, rdy, dir;
      logic [4:0]   wa, la, r1, r2;
      logic [N-1:0] wd, ld;
      logic         e_we, m1, m2;
      logic [4:0]   e_wa;
      logic [N-1:0] e_wd, d1, d2;
      int           sz;
      string        s;
      wv = ($urandom % 2) == 0;
      wa = 5'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      lv = ($urandom % 5) < 3;
      la = 5'($urandom_range(0, 7));
      ld = {$urandom, $urandom};
      fl = ($urandom % 16) == 0;
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      drive(wv, wa, wd, lv, la, ld, fl, r1, r2);
      sz  = q.size();
      wbg = wv && wa != 0;
      rdy = sz < DEPTH;
      dir = 1'b0;
      e_we = 1'b0; e_wa = '0; e_wd = '0;
      if (wbg) begin
         e_we = 1'b1; e_wa = wa; e_wd = wd;
      end else if (!fl && sz > 0) begin
         if (q[0].v) begin
            e_we = 1'b1; e_wa = q[0].a; e_wd = q[0].d;
         end
      end else if (!fl && lv && la != 0) begin
         dir = 1'b1;
         e_we = 1'b1; e_wa = la; e_wd = ld;
      end
      m1 = 1'b0; m2 = 1'b0; d1 = '0; d2 = '0;
      for (int i = sz - 1; i >= 0; i--) begin
         if (!m1 && r1 != 0 && q[i].v && q[i].a == r1) begin
            m1 = 1'b1; d1 = q[i].d;
         end
         if (!m2 && r2 != 0 && q[i].v && q[i].a == r2) begin
            m2 = 1'b1; d2 = q[i].d;
         end
      end
      @(negedge clk);
      s = $sformatf("r%0d", n);
      chk({s, "_we3"}, N'(we3), N'(e_we));
      chk({s, "_wa3"}, N'(wa3), N'(e_wa));
      chk({s, "_wd3"}, wd3, e_wd);
      chk({s, "_rdy"}, N'(lnk_ready), N'(rdy));
      chk({s, "_cnt"}, N'(count), N'(sz));
      chk_match({s, "_p1"}, m1, d1, hz1, fwd1_valid, fwd1_data, 1'b1);
      chk_match({s, "_p2"}, m2, d2, hz2, fwd2_valid, fwd2_data, 1'b1);
      if (fl) begin
         q.delete();
      end else begin
         if (wbg)
            foreach (q[i]) if (q[i].a == wa) q[i].v = 1'b0;
         if (!wbg && sz > 0) void'(q.pop_front());
         if (lv && la != 0 && rdy && !dir)
            q.push_back('{v: 1'b1, a: la, d: ld});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 0, '0, 0, 0, '0, 0, 0, 0);

      tbl.push_back(mk(0,0,0,      0,0,0,         0,0,0,   0,0,0,       1,0,0,0));
      tbl.push_back(mk(0,0,0,      1,1,'h1004,    0,0,0,   1,1,'h1004,  1,0,0,0));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,0,0,   0,0,0,       1,0,0,0));
      tbl.push_back(mk(1,5,'h55,   1,1,'h2004,    0,0,0,   1,5,'h55,    1,0,0,0));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,1,0,   1,1,'h2004,  1,1,1,0));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,0,0,   0,0,0,       1,0,0,0));
      tbl.push_back(mk(1,6,'h66,   1,2,'h3000,    0,0,0,   1,6,'h66,    1,0,0,0));
      tbl.push_back(mk(1,8,'h88,   1,3,'h3004,    0,0,0,   1,8,'h88,    1,1,0,0));
      tbl.push_back(mk(1,9,'h99,   1,4,'h3008,    0,2,3,   1,9,'h99,    0,2,1,1));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,0,0,   1,2,'h3000,  0,2,0,0));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,0,0,   1,3,'h3004,  1,1,0,0));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,0,0,   0,0,0,       1,0,0,0));
      tbl.push_back(mk(1,10,'hA0,  1,3,'h4000,    0,0,0,   1,10,'hA0,   1,0,0,0));
      tbl.push_back(mk(1,3,'hAA,   0,0,0,         0,3,0,   1,3,'hAA,    1,1,1,0));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,3,0,   0,0,0,       1,1,0,0));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,0,0,   0,0,0,       1,0,0,0));
      tbl.push_back(mk(1,11,'hB1,  1,7,'h7777,    0,0,0,   1,11,'hB1,   1,0,0,0));
      tbl.push_back(mk(1,12,'hC1,  0,0,0,         0,7,0,   1,12,'hC1,   1,1,1,0));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,7,0,   1,7,'h7777,  1,1,1,0));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,0,0,   0,0,0,       1,0,0,0));
      tbl.push_back(mk(1,13,'hD1,  1,20,'h20,     0,0,0,   1,13,'hD1,   1,0,0,0));
      tbl.push_back(mk(1,14,'hE1,  1,21,'h21,     0,0,0,   1,14,'hE1,   1,1,0,0));
      tbl.push_back(mk(1,15,'hF1,  1,22,'h22,     1,20,21, 1,15,'hF1,   0,2,1,1));
      tbl.push_back(mk(0,0,0,      1,23,'h23,     0,0,0,   1,23,'h23,   1,0,0,0));
      tbl.push_back(mk(0,0,0,      1,0,'h5,       0,0,0,   0,0,0,       1,0,0,0));
      tbl.push_back(mk(1,0,'h9,    1,0,'h6,       0,0,0,   0,0,0,       1,0,0,0));
      tbl.push_back(mk(0,0,0,      1,9,'h9,       1,0,0,   0,0,0,       1,0,0,0));
      tbl.push_back(mk(0,0,0,      0,0,0,         0,0,0,   0,0,0,       1,0,0,0));

      #12;
      chk("rst_we3", N'(we3), '0);
      chk("rst_wa3", N'(wa3), '0);
      chk("rst_wd3", wd3, '0);
      chk("rst_cnt", N'(count), '0);
      chk("rst_rdy", N'(lnk_ready), N'(1'b1));
      chk("rst_hz1", N'(hz1), '0);
      chk("rst_fwd1", N'(fwd1_valid), '0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) apply(tbl[i], i);

      // Reset in the middle of a drain empties the buffer at once.
      drive(1, 1, 'h11, 1, 4, 'h44, 0, 0, 0);
      @(posedge clk); #1;
      drive(1, 2, 'h22, 1, 5, 'h55, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 0, '0, 0, 0, '0, 0, 0, 0);
      #1;
      chk("md_cnt", N'(count), N'(2));
      chk("md_we3", N'(we3), N'(1'b1));
      chk("md_wa3", N'(wa3), N'(5'd4));
      chk("md_wd3", wd3, 'h44);
      #1;
      reset = 1'b0;
      #1;
      chk("mdr_we3", N'(we3), '0);
      chk("mdr_cnt", N'(count), '0);
      chk("mdr_rdy", N'(lnk_ready), N'(1'b1));
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mdr_post_we3", N'(we3), '0);
      chk("mdr_post_cnt", N'(count), '0);

      q.delete();
      for (int i = 0; i < 3000; i++) rand_step(i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
